// File: rtl/alu_flag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_flag_pkg
// Description : Shared definitions for the ALU flag register block:
//               flag vector width, flag bit positions and the flag type.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_flag_pkg;

  // Number of architectural flags
  localparam int FLAG_W = 5;

  // Bit positions inside a flag vector
  localparam int FLAG_Z = 0;  // zero
  localparam int FLAG_S = 1;  // sign
  localparam int FLAG_C = 2;  // carry
  localparam int FLAG_V = 3;  // overflow
  localparam int FLAG_P = 4;  // 8-bit even parity

  typedef logic [FLAG_W-1:0] flags_t;

endpackage : alu_flag_pkg
`default_nettype wire

// File: rtl/alu_flag_register_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_flag_register_if
// Description : Control/data bundle between the flag register and its
//               environment (ALU flag stages, sequencer, branch logic).
//   master : drives notFlagIn, UpdateMask, FlagWrite, FlagWriteData,
//            Push, Pop, ErrClear; observes the flag/stack outputs.
//   slave  : the flag register itself (the opposite directions).
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_flag_register_if
  import alu_flag_pkg::*;
#(
  parameter int CNT_W = 3
);

  flags_t             notFlagIn;      // active-low flags from the ALU
  flags_t             UpdateMask;     // 1 = flag takes ALU value
  logic               FlagWrite;      // direct load of all flags
  flags_t             FlagWriteData;  // active-high direct-load value
  logic               Push;           // save Flags onto the stack
  logic               Pop;            // restore Flags from the stack
  logic               ErrClear;       // clear the sticky error
  flags_t             Flags;          // registered flags, active-high
  flags_t             notFlags;       // registered complement of Flags
  logic [CNT_W-1:0]   StackCount;     // occupied stack entries
  logic               StackFull;
  logic               StackEmpty;
  logic               StackErr;       // sticky misuse indicator

  modport master (
    output notFlagIn, UpdateMask, FlagWrite, FlagWriteData,
           Push, Pop, ErrClear,
    input  Flags, notFlags, StackCount, StackFull, StackEmpty, StackErr
  );

  modport slave (
    input  notFlagIn, UpdateMask, FlagWrite, FlagWriteData,
           Push, Pop, ErrClear,
    output Flags, notFlags, StackCount, StackFull, StackEmpty, StackErr
  );

endinterface : alu_flag_register_if
`default_nettype wire

// File: rtl/alu_flag_stack.sv
`default_nettype none
// ============================================================================
// Module      : alu_flag_stack
// Description : DEPTH x FLAG_W LIFO used to save/restore flags across
//               interrupt entry and return. A single occupancy counter is
//               both the stack pointer and the count.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_push, i_pop     : requests (simultaneous requests are both refused)
//   i_data            : value written on an accepted push
//   o_top             : entry at count-1 (valid when not empty)
//   o_pop_ok          : current pop request is accepted
//   o_err             : current request is a misuse (strobe)
//   o_count/o_full/o_empty : occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module alu_flag_stack
  import alu_flag_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst,
  input  wire logic             i_push,
  input  wire logic             i_pop,
  input  wire flags_t           i_data,
  output logic                  o_pop_ok,
  output logic                  o_err,
  output flags_t                o_top,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int ADDR_W = $clog2(DEPTH);

  flags_t             r_mem [DEPTH];
  logic [CNT_W-1:0]   r_count;

  logic               w_full;
  logic               w_empty;
  logic               w_push_ok;
  logic               w_pop_ok;
  logic [ADDR_W-1:0]  w_wr_idx;
  logic [ADDR_W-1:0]  w_rd_idx;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);

  // A simultaneous push and pop is treated as a misuse: neither happens.
  assign w_push_ok = i_push & ~i_pop & ~w_full;
  assign w_pop_ok  = i_pop & ~i_push & ~w_empty;

  // With count in 0..DEPTH-1 the low bits are the write slot directly.
  // For the read slot, count==DEPTH has zero low bits and wraps to DEPTH-1.
  assign w_wr_idx  = r_count[ADDR_W-1:0];
  assign w_rd_idx  = r_count[ADDR_W-1:0] - ADDR_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (w_push_ok) begin
      r_count <= r_count + CNT_W'(1);
    end else if (w_pop_ok) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage carries no reset; contents are meaningless while unoccupied.
  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_rst) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

  assign o_top    = r_mem[w_rd_idx];
  assign o_pop_ok = w_pop_ok;
  assign o_err    = (i_push & i_pop) | (i_push & w_full) | (i_pop & w_empty);
  assign o_count  = r_count;
  assign o_full   = w_full;
  assign o_empty  = w_empty;

  a_count_bound : assert property (@(posedge i_clk) r_count <= CNT_W'(DEPTH));

endmodule : alu_flag_stack
`default_nettype wire

// File: rtl/alu_flag_register.sv
`default_nettype none
// ============================================================================
// Module      : alu_flag_register
// Description : Architectural flag register. Latches active-low ALU flags
//               under a per-flag mask, supports a direct load and a
//               save/restore stack, and drives registered flags in both
//               polarities.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : alu_flag_register_if.slave (ALU flags, mask, direct load,
//              push/pop/err-clear in; Flags, notFlags and stack status out)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_flag_register
  import alu_flag_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  wire logic           CLK,
  input  wire logic           RST,
  alu_flag_register_if.slave  bus
);

  flags_t             r_flags;
  flags_t             r_nflags;
  logic               r_err;

  flags_t             w_flags_next;
  flags_t             w_stack_top;
  logic               w_pop_ok;
  logic               w_stack_err;
  logic [CNT_W-1:0]   w_count;
  logic               w_full;
  logic               w_empty;

  alu_flag_stack #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_stack (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_push   (bus.Push),
    .i_pop    (bus.Pop),
    .i_data   (r_flags),       // pre-edge flags are what gets saved
    .o_pop_ok (w_pop_ok),
    .o_err    (w_stack_err),
    .o_top    (w_stack_top),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // Priority: accepted pop, then direct load, then masked ALU update.
  always_comb begin
    w_flags_next = r_flags;
    if (w_pop_ok) begin
      w_flags_next = w_stack_top;
    end else if (bus.FlagWrite) begin
      w_flags_next = bus.FlagWriteData;
    end else begin
      w_flags_next = (r_flags & ~bus.UpdateMask) | (~bus.notFlagIn & bus.UpdateMask);
    end
  end

  // The complement is kept in its own register so both polarities leave
  // the block straight from flops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_flags  <= '0;
      r_nflags <= '1;
      r_err    <= 1'b0;
    end else begin
      r_flags  <= w_flags_next;
      r_nflags <= ~w_flags_next;
      if (w_stack_err) begin
        r_err <= 1'b1;
      end else if (bus.ErrClear) begin
        r_err <= 1'b0;
      end
    end
  end

  assign bus.Flags      = r_flags;
  assign bus.notFlags   = r_nflags;
  assign bus.StackCount = w_count;
  assign bus.StackFull  = w_full;
  assign bus.StackEmpty = w_empty;
  assign bus.StackErr   = r_err;

  a_polarity : assert property (@(posedge CLK) disable iff (RST)
                                r_nflags == ~r_flags);

endmodule : alu_flag_register
`default_nettype wire

// File: doc/alu_flag_register.md
Name: alu_flag_register

Overview:
- Downstream of the ALU flag stages, including the 8-bit even-parity flag stage.
- Latches the active-low, dual-rail-derived flag outputs into an architectural flag register under a per-flag update mask.
- Provides a shallow save/restore stack for interrupt entry and return, plus a direct-load path for flag-restore instructions.
- Drives registered flags in both polarities (Flags / notFlags) to branch-condition logic and back to the ALU carry-in.

Parameters:
- FLAG_W, 5, number of flags. Bit order: [0]=Z, [1]=S, [2]=C, [3]=V, [4]=P.
- DEPTH, 4, save-stack entries (power of two, ≥2).
- CNT_W, 3, width of StackCount (clog2(DEPTH)+1).

Ports:
- CLK  in  1  sole clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- notFlagIn  in  FLAG_W  active-low flags from ALU flag stages; [4] is notIs8bitEvenParity.
- UpdateMask  in  FLAG_W  1 = flag takes the ALU value this cycle.
- FlagWrite  in  1  load FlagWriteData into all flags.
- FlagWriteData  in  FLAG_W  active-high direct-load value.
- Push  in  1  save current Flags onto the stack.
- Pop  in  1  restore Flags from the stack top.
- ErrClear  in  1  clear StackErr.
- Flags  out  FLAG_W  registered flags, active-high.
- notFlags  out  FLAG_W  always the bitwise complement of Flags; registered, not derived combinationally.
- StackCount  out  CNT_W  occupied stack entries, 0..DEPTH.
- StackFull  out  1  StackCount == DEPTH.
- StackEmpty  out  1  StackCount == 0.
- StackErr  out  1  sticky misuse indicator.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high (CLK, RST).
- Reset values: Flags=0, notFlags=all ones, StackCount=0, StackEmpty=1, StackFull=0, StackErr=0. Stack contents are don't-care. RST overrides every other input in the same cycle.
- Latency: inputs sampled at edge N appear on outputs after edge N. No combinational input-to-output path.
- Next-flag priority:
  1. valid Pop → Flags = stack[top]
  2. FlagWrite → Flags = FlagWriteData
  3. otherwise, per bit i: UpdateMask[i] ? ~notFlagIn[i] : hold
- Push:
  - Writes the pre-edge Flags value into stack[StackCount]; count+1.
  - A same-cycle UpdateMask or FlagWrite still applies to Flags, so the saved value is the old one.
- Valid Pop: count-1, Flags loaded from entry count-1.
- Push with StackCount==DEPTH: ignored (no overwrite, no wrap); StackErr←1.
- Pop with StackCount==0: ignored. Flags follow rule 2/3 instead; StackErr←1.
- Push and Pop in the same cycle: both ignored, stack unchanged, StackErr←1. Flags follow rule 2/3.
- StackErr: set as above; cleared by ErrClear. If set and clear coincide, set wins. Cleared by RST.
- FlagWrite with mask bits set: FlagWrite wins; mask is ignored.
- Implementation rule: internal stack pointer and count are a single register (no separate head/tail). Full/Empty are decoded from StackCount, registered by construction.
- Assertions: notFlags == ~Flags every cycle after reset. StackCount never exceeds DEPTH.

Decomposition:
- Shared package alu_flag_pkg holds:
  - flag index constants FLAG_Z=0, FLAG_S=1, FLAG_C=2, FLAG_V=3, FLAG_P=4;
  - FLAG_W=5;
  - flag-vector typedef flags_t.
- One natural sub-module: alu_flag_stack, a DEPTH×FLAG_W LIFO with push/pop/count/full/empty and error strobes.
- The top holds the flag register, the priority mux and the sticky error bit.

Test Plan:
- Reset, then notFlagIn=5'b01111, UpdateMask=5'b11111 → after 1 edge Flags=5'b10000 (P=1), notFlags=5'b01111; before that edge Flags=0.
- Flags=5'b10101, UpdateMask=5'b00100, notFlagIn=5'b11111 → Flags=5'b10001; other bits held.
- Flags=5'b00011, Push together with FlagWrite=1, FlagWriteData=5'b11100 → Flags=5'b11100, StackCount=1. Next, Pop → Flags=5'b00011, StackCount=0, StackEmpty=1.
- Four Pushes of distinct values 1, 2, 3, 4 → StackFull=1. Fifth Push → StackCount stays 4, StackErr=1. Four Pops return 4, 3, 2, 1.
- Pop while empty with UpdateMask=5'b00001, notFlagIn=5'b11110 → Z=1, StackErr=1. ErrClear → StackErr=0 next cycle.
- Push and Pop together at StackCount=2 → count stays 2, StackErr=1. RST asserted mid-sequence → all outputs return to reset values next edge.
